// File: rtl/key_irq_ctrl.sv
// Debounced 8-key front end: press events latch into W1C pending bits and raise a maskable IRQ.
// Latency: pin change to stable/pending is 2 sync cycles + DEBOUNCE_CYCLES; RD and IRQ are combinational from registers.
// Backpressure: none; register writes complete in one cycle and reads are always valid.
module key_irq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  Key,
  input  logic        Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       stable;
  logic [7:0]       pending;
  logic [7:0]       mask;
  logic [CNT_W-1:0] cnt [8];

  logic [7:0]       stable_nxt;
  logic [7:0]       rise;
  logic [CNT_W-1:0] cnt_nxt [8];
  logic [7:0]       clr;
  logic [7:0]       pending_nxt;
  logic             wr_ctrl;
  logic             unused_wd;

  assign unused_wd = ^WD[31:16];

  // The counter only advances while the synchronised key disagrees with stable,
  // so any disagreement shorter than DEBOUNCE_CYCLES cycles is discarded.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      stable_nxt[i] = stable[i];
      cnt_nxt[i]    = '0;
      rise[i]       = 1'b0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
          rise[i]       = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  assign wr_ctrl = WE & Addr;
  assign clr     = wr_ctrl ? WD[7:0] : 8'h00;
  // A press completing on the same edge as its W1C wins.
  assign pending_nxt = (pending & ~clr) | rise;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      pending <= '0;
      mask    <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= ~Key;
      sync2   <= sync1;
      stable  <= stable_nxt;
      pending <= pending_nxt;
      if (wr_ctrl) begin
        mask <= WD[15:8];
      end
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign RD  = Addr ? {16'h0000, mask, pending} : {24'h000000, stable};
  assign IRQ = |(pending & mask);

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Directed bench for key_irq_ctrl with DEBOUNCE_CYCLES=4: debounce latency, glitch rejection,
// W1C, set-wins-over-clear, masking and reset with a key held.
module tb_key_irq_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  Key;
  logic        Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  key_irq_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Key   (Key),
    .Addr  (Addr),
    .WE    (WE),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic a, input string tag, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, RD, exp);
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    Addr = 1'b1;
    WE   = 1'b1;
    WD   = d;
    step(1);
    WE   = 1'b0;
    WD   = 32'h0;
  endtask

  initial begin
    Reset = 1'b1;
    Key   = 8'hFF;
    Addr  = 1'b0;
    WE    = 1'b0;
    WD    = 32'h0;
    step(2);
    rd(1'b0, "rst_state", 32'h0);
    rd(1'b1, "rst_ctrl", 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);

    // Idle keys after reset
    Reset = 1'b0;
    step(10);
    rd(1'b0, "idle_state", 32'h0);
    rd(1'b1, "idle_ctrl", 32'h0);
    chk("idle_irq", {31'h0, IRQ}, 32'h0);

    // Mask key 3, then press it: visible exactly 6 edges after the pin change
    wr_ctrl(32'h0000_0800);
    rd(1'b1, "mask_wr", 32'h0000_0800);
    Key = 8'hF7;
    step(5);
    rd(1'b0, "k3_edge5_state", 32'h0);
    rd(1'b1, "k3_edge5_ctrl", 32'h0000_0800);
    chk("k3_edge5_irq", {31'h0, IRQ}, 32'h0);
    step(1);
    rd(1'b0, "k3_edge6_state", 32'h0000_0008);
    rd(1'b1, "k3_edge6_ctrl", 32'h0000_0808);
    step(1);
    chk("k3_irq", {31'h0, IRQ}, 32'h1);

    // 3-cycle glitch on key 5 is rejected
    Key = 8'hD7;
    step(3);
    Key = 8'hF7;
    step(5);
    rd(1'b0, "glitch_state", 32'h0000_0008);
    rd(1'b1, "glitch_ctrl", 32'h0000_0808);
    chk("glitch_irq", {31'h0, IRQ}, 32'h1);
    chk("glitch_cnt5", 32'(dut.cnt[5]), 32'h0);

    // W1C of key 3 keeps the mask; release sets nothing
    wr_ctrl(32'h0000_0808);
    rd(1'b1, "w1c_ctrl", 32'h0000_0800);
    chk("w1c_irq", {31'h0, IRQ}, 32'h0);
    Key = 8'hFF;
    step(8);
    rd(1'b0, "rel_state", 32'h0);
    rd(1'b1, "rel_ctrl", 32'h0000_0800);
    chk("rel_irq", {31'h0, IRQ}, 32'h0);

    // Key 0 debounce completes on the same edge as a W1C of bit 0: set wins
    Key = 8'hFE;
    step(5);
    rd(1'b1, "k0_edge5_ctrl", 32'h0000_0800);
    wr_ctrl(32'h0000_0801);
    rd(1'b1, "setwins_ctrl", 32'h0000_0801);
    rd(1'b0, "setwins_state", 32'h0000_0001);
    chk("setwins_irq", {31'h0, IRQ}, 32'h0);
    wr_ctrl(32'h0000_0801);
    rd(1'b1, "k0_w1c_ctrl", 32'h0000_0800);
    Key = 8'hFF;
    step(8);
    wr_ctrl(32'h0000_0000);
    rd(1'b1, "mask_clr_ctrl", 32'h0);
    rd(1'b0, "k0_rel_state", 32'h0);

    // Key 7 held, reset pulsed mid-count
    Key = 8'h7F;
    step(3);
    Reset = 1'b1;
    step(1);
    rd(1'b0, "midrst_state", 32'h0);
    rd(1'b1, "midrst_ctrl", 32'h0);
    chk("midrst_irq", {31'h0, IRQ}, 32'h0);
    chk("midrst_cnt7", 32'(dut.cnt[7]), 32'h0);
    Reset = 1'b0;
    step(5);
    rd(1'b1, "k7_edge5_ctrl", 32'h0);
    step(1);
    rd(1'b1, "k7_edge6_ctrl", 32'h0000_0080);
    rd(1'b0, "k7_edge6_state", 32'h0000_0080);
    chk("k7_irq_masked", {31'h0, IRQ}, 32'h0);
    wr_ctrl(32'h0000_8000);
    chk("k7_irq_unmasked", {31'h0, IRQ}, 32'h1);
    rd(1'b1, "k7_final_ctrl", 32'h0000_8080);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
